keypad_emulator: RTL

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/keypad_key_map.sv | 32 +++
 rtl/keypad_emulator.sv | 122 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad constants: key indices, row/column one-hot codes and FSM encoding.
// Imported by the emulator and by any other keypad block.
package keypad_pkg;

    localparam logic [3:0] KEY_1     = 4'd0;
    localparam logic [3:0] KEY_2     = 4'd1;
    localparam logic [3:0] KEY_3     = 4'd2;
    localparam logic [3:0] KEY_4     = 4'd3;
    localparam logic [3:0] KEY_5     = 4'd4;
    localparam logic [3:0] KEY_6     = 4'd5;
    localparam logic [3:0] KEY_7     = 4'd6;
    localparam logic [3:0] KEY_8     = 4'd7;
    localparam logic [3:0] KEY_9     = 4'd8;
    localparam logic [3:0] KEY_STAR  = 4'd9;
    localparam logic [3:0] KEY_0     = 4'd10;
    localparam logic [3:0] KEY_HASH  = 4'd11;
    localparam logic [3:0] NUM_KEYS  = 4'd12;

    // Rows are listed top to bottom of the physical pad.
    localparam logic [3:0] ROW_123   = 4'b0100;
    localparam logic [3:0] ROW_456   = 4'b0010;
    localparam logic [3:0] ROW_789   = 4'b0001;
    localparam logic [3:0] ROW_S0H   = 4'b1000;
    localparam logic [3:0] ROW_NONE  = 4'b0000;

    localparam logic [2:0] COL_LEFT  = 3'b100;
    localparam logic [2:0] COL_MID   = 3'b010;
    localparam logic [2:0] COL_RIGHT = 3'b001;
    localparam logic [2:0] COL_NONE  = 3'b000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_BOUNCE = 2'd1;
    localparam state_t ST_HOLD   = 2'd2;
    localparam state_t ST_GAP    = 2'd3;

    function automatic logic key_is_valid(input logic [3:0] key);
        return key < NUM_KEYS;
    endfunction

endpackage

// File: rtl/keypad_key_map.sv
// Combinational key index -> {row, column, valid} decode for a 4x3 keypad.
module keypad_key_map
    import keypad_pkg::*;
(
    input  logic [3:0] key_idx_i,
    output logic [3:0] row_o,
    output logic [2:0] col_o,
    output logic       valid_o
);

    always_comb begin
        row_o   = ROW_NONE;
        col_o   = COL_NONE;
        valid_o = 1'b1;
        case (key_idx_i)
            KEY_1:    begin row_o = ROW_123; col_o = COL_LEFT;  end
            KEY_2:    begin row_o = ROW_123; col_o = COL_MID;   end
            KEY_3:    begin row_o = ROW_123; col_o = COL_RIGHT; end
            KEY_4:    begin row_o = ROW_456; col_o = COL_LEFT;  end
            KEY_5:    begin row_o = ROW_456; col_o = COL_MID;   end
            KEY_6:    begin row_o = ROW_456; col_o = COL_RIGHT; end
            KEY_7:    begin row_o = ROW_789; col_o = COL_LEFT;  end
            KEY_8:    begin row_o = ROW_789; col_o = COL_MID;   end
            KEY_9:    begin row_o = ROW_789; col_o = COL_RIGHT; end
            KEY_STAR: begin row_o = ROW_S0H; col_o = COL_LEFT;  end
            KEY_0:    begin row_o = ROW_S0H; col_o = COL_MID;   end
            KEY_HASH: begin row_o = ROW_S0H; col_o = COL_RIGHT; end
            default:  valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one key closure on a scanned 4x3 keypad: optional bounce, solid hold,
// then a release gap, returning the latched key's column when its row is driven.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50000,
    parameter int GAP_CYCLES    = 10000,
    parameter int BOUNCE_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_key,
    output logic       cmd_ready,
    output logic       pressed,
    output logic       done,
    output logic       err
);

    localparam logic [23:0] HOLD_LAST   = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] GAP_LAST    = 24'(GAP_CYCLES - 1);
    localparam logic [23:0] BOUNCE_LAST = 24'(BOUNCE_CYCLES - 1);
    localparam state_t      FIRST_ST    = (BOUNCE_CYCLES > 0) ? ST_BOUNCE : ST_HOLD;
    localparam state_t      AFTER_HOLD  = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  key_q, key_d;
    logic [2:0]  col_q, col_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        contact;

    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic        key_ok;

    keypad_key_map u_key_map (
        .key_idx_i (key_q),
        .row_o     (key_row),
        .col_o     (key_col),
        .valid_o   (key_ok)
    );

    // Bounce closes on its first cycle and alternates, so contact follows counter bit 0.
    always_comb begin
        case (state_q)
            ST_BOUNCE: contact = ~cnt_q[0];
            ST_HOLD:   contact = 1'b1;
            default:   contact = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 24'd1;
        key_d   = key_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        col_d   = (contact && key_ok && (row_in == key_row)) ? key_col : COL_NONE;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cmd_valid) begin
                    key_d = cmd_key;
                    if (key_is_valid(cmd_key)) begin
                        state_d = FIRST_ST;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BOUNCE: begin
                if (cnt_q == BOUNCE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = AFTER_HOLD;
                    cnt_d   = '0;
                    done_d  = (AFTER_HOLD == ST_IDLE);
                end
            end
            default: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            col_q   <= col_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign col_out   = col_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign pressed   = (state_q == ST_BOUNCE) || (state_q == ST_HOLD);
    assign done      = done_q;
    assign err       = err_q;

endmodule
